// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver.
// Parity modes, FSM encoding and parity calculation.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Expected parity bit for a zero-extended data word.
  function automatic logic par_calc(
    input logic [8:0] d,
    input int         mode
  );
    logic p;
    p = ^d;
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX synchroniser and mid-bit 3-sample majority vote.
// Phase is owned by the FSM; this block only compares it.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OS = 16,
  parameter int PW = $clog2(OS)
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          os_tick,
  input  logic          RX,
  input  logic [PW-1:0] phase,
  output logic          rx_sync,
  output logic          sample_bit,
  output logic          vote_done,
  output logic          bit_done
);

  localparam logic [PW-1:0] PH_S0   = PW'(OS / 2 - 1);
  localparam logic [PW-1:0] PH_S1   = PW'(OS / 2);
  localparam logic [PW-1:0] PH_S2   = PW'(OS / 2 + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(OS - 1);

  logic [1:0] sync_q, sync_d;
  logic       s0_q, s0_d;
  logic       s1_q, s1_d;
  logic       maj_q, maj_d;
  logic       vote;

  assign rx_sync = sync_q[1];

  // Third sample is taken live on the vote tick.
  assign vote = (s0_q & s1_q)
              | (s0_q & rx_sync)
              | (s1_q & rx_sync);

  assign vote_done  = os_tick && (phase == PH_S2);
  assign bit_done   = os_tick && (phase == PH_LAST);
  assign sample_bit = (phase == PH_S2) ? vote : maj_q;

  always_comb begin
    sync_d = {sync_q[0], RX};
    s0_d   = s0_q;
    s1_d   = s1_q;
    maj_d  = maj_q;
    if (os_tick) begin
      if (phase == PH_S0) s0_d = rx_sync;
      if (phase == PH_S1) s1_d = rx_sync;
      if (phase == PH_S2) maj_d = vote;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      sync_q <= 2'b11;
      s0_q   <= 1'b1;
      s1_q   <= 1'b1;
      maj_q  <= 1'b1;
    end else begin
      sync_q <= sync_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      maj_q  <= maj_d;
    end
  end

endmodule

// File: rtl/uart_rx_ex.sv
// Oversampling UART receiver with error reporting
// and a one-entry valid/ready output buffer.
module uart_rx_ex
  import uart_pkg::*;
#(
  parameter int OS        = 16,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              os_tick,
  input  logic              RX,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              parity_err,
  output logic              framing_err,
  output logic              break_det,
  output logic              overrun
);

  localparam int PW = $clog2(OS);
  localparam int BW = $clog2(DATA_W);
  localparam logic [PW-1:0] PH_LAST = PW'(OS - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_W - 1);

  rx_state_e           state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [BW-1:0]       bit_idx_q, bit_idx_d;
  logic                stop_idx_q, stop_idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                brk_q, brk_d;
  logic                ovr_q, ovr_d;

  logic rx_sync, sample_bit, vote_done, bit_done;
  logic good, fail, last_stop, is_break;

  uart_rx_sampler #(
    .OS (OS),
    .PW (PW)
  ) u_sampler (
    .CLK        (CLK),
    .rst        (rst),
    .os_tick    (os_tick),
    .RX         (RX),
    .phase      (phase_q),
    .rx_sync    (rx_sync),
    .sample_bit (sample_bit),
    .vote_done  (vote_done),
    .bit_done   (bit_done)
  );

  assign last_stop = (STOP_BITS == 1) || stop_idx_q;
  assign is_break  = (shift_q == '0)
                  && ((PARITY == PAR_NONE) || !par_q);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    good       = 1'b0;
    fail       = 1'b0;
    if (os_tick) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          phase_d = '0;
          if (!rx_sync) begin
            phase_d = PW'(1);
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            if (sample_bit) begin
              state_d = ST_IDLE;
            end else begin
              bit_idx_d = '0;
              state_d   = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shift_d = {sample_bit, shift_q[DATA_W-1:1]};
            if (bit_idx_q == IDX_LAST) begin
              stop_idx_d = 1'b0;
              state_d    = (PARITY != PAR_NONE)
                         ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            par_d   = sample_bit;
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          // Final stop bit ends at its vote tick for resync margin.
          if (vote_done && !sample_bit) begin
            fail = 1'b1;
          end else if (vote_done && last_stop) begin
            good = 1'b1;
          end else if (bit_done) begin
            stop_idx_d = 1'b1;
          end
          if (good || fail) begin
            phase_d = '0;
            state_d = (fail && is_break) ? ST_BREAK : ST_IDLE;
          end
        end
        ST_BREAK: begin
          phase_d = '0;
          if (rx_sync) state_d = ST_IDLE;
        end
        default: begin
          phase_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    perr_d    = 1'b0;
    ferr_d    = fail && !is_break;
    brk_d     = fail && is_break;
    ovr_d     = 1'b0;
    if (good) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = shift_q;
        m_valid_d = 1'b1;
        perr_d    = (PARITY != PAR_NONE)
                 && (par_q != par_calc(9'(shift_q), PARITY));
      end else begin
        ovr_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign break_det   = brk_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_ex.sv
// Bench for uart_rx_ex: three instances (8N1, 8E1, 9N2)
// driven by directed and random frames against a frame-level model.
module tb_uart_rx_ex;

  localparam int BIT = 64;

  logic CLK = 1'b0;
  logic os_tick = 1'b0;
  logic [1:0] div = 2'd0;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic mr_a = 1'b1, mr_b = 1'b1, mr_c = 1'b1;
  logic [7:0] md_a, md_b;
  logic [8:0] md_c;
  logic mv_a, mv_b, mv_c;
  logic pe_a, pe_b, pe_c;
  logic fe_a, fe_b, fe_c;
  logic bk_a, bk_b, bk_c;
  logic ov_a, ov_b, ov_c;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    div     <= div + 2'd1;
    os_tick <= (div == 2'd3);
  end

  uart_rx_ex u_a (
    .CLK(CLK), .rst(rst_a), .os_tick(os_tick), .RX(rx_a),
    .m_data(md_a), .m_valid(mv_a), .m_ready(mr_a),
    .parity_err(pe_a), .framing_err(fe_a),
    .break_det(bk_a), .overrun(ov_a)
  );

  uart_rx_ex #(.PARITY(1)) u_b (
    .CLK(CLK), .rst(rst_b), .os_tick(os_tick), .RX(rx_b),
    .m_data(md_b), .m_valid(mv_b), .m_ready(mr_b),
    .parity_err(pe_b), .framing_err(fe_b),
    .break_det(bk_b), .overrun(ov_b)
  );

  uart_rx_ex #(.DATA_W(9), .STOP_BITS(2)) u_c (
    .CLK(CLK), .rst(rst_c), .os_tick(os_tick), .RX(rx_c),
    .m_data(md_c), .m_valid(mv_c), .m_ready(mr_c),
    .parity_err(pe_c), .framing_err(fe_c),
    .break_det(bk_c), .overrun(ov_c)
  );

  logic [8:0] got_a[$];
  logic [8:0] got_b[$];
  logic [8:0] got_c[$];
  int pe[3] = '{0, 0, 0};
  int fe[3] = '{0, 0, 0};
  int bk[3] = '{0, 0, 0};
  int ov[3] = '{0, 0, 0};

  always @(negedge CLK) begin
    if (mv_a && mr_a) got_a.push_back(9'(md_a));
    if (mv_b && mr_b) got_b.push_back(9'(md_b));
    if (mv_c && mr_c) got_c.push_back(md_c);
    pe[0] += int'(pe_a); pe[1] += int'(pe_b); pe[2] += int'(pe_c);
    fe[0] += int'(fe_a); fe[1] += int'(fe_b); fe[2] += int'(fe_c);
    bk[0] += int'(bk_a); bk[1] += int'(bk_b); bk[2] += int'(bk_c);
    ov[0] += int'(ov_a); ov[1] += int'(ov_b); ov[2] += int'(ov_c);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int bdv[3], bpe[3], bfe[3], bbk[3], bov[3];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic int gsize(input int d);
    case (d)
      0: return got_a.size();
      1: return got_b.size();
      default: return got_c.size();
    endcase
  endfunction

  function automatic logic [8:0] gat(input int d, input int i);
    case (d)
      0: return got_a[i];
      1: return got_b[i];
      default: return got_c[i];
    endcase
  endfunction

  task automatic set_rx(input int d, input logic v);
    case (d)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic snap(input int d);
    bdv[d] = gsize(d);
    bpe[d] = pe[d];
    bfe[d] = fe[d];
    bbk[d] = bk[d];
    bov[d] = ov[d];
  endtask

  task automatic deltas(input string tag, input int d,
                        input int dv, input int p, input int f,
                        input int b, input int o);
    chk({tag, "/deliv"}, 32'(gsize(d) - bdv[d]), 32'(dv));
    chk({tag, "/perr"}, 32'(pe[d] - bpe[d]), 32'(p));
    chk({tag, "/ferr"}, 32'(fe[d] - bfe[d]), 32'(f));
    chk({tag, "/brk"}, 32'(bk[d] - bbk[d]), 32'(b));
    chk({tag, "/ovr"}, 32'(ov[d] - bov[d]), 32'(o));
  endtask

  // Serial frame image: start, data LSB first, parity, stops.
  function automatic logic [15:0] mk(input logic [8:0] d,
                                     input int w, input int pm,
                                     input logic pb, input int ns,
                                     input logic sv);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < w; i++) begin
      f[k] = d[i];
      k++;
    end
    if (pm != 0) begin
      f[k] = pb;
      k++;
    end
    for (int i = 0; i < ns; i++) begin
      f[k] = sv;
      k++;
    end
    return f;
  endfunction

  function automatic int flen(input int w, input int pm,
                              input int ns);
    return 1 + w + ((pm != 0) ? 1 : 0) + ns;
  endfunction

  // Even parity: total ones over data plus parity bit must be even.
  function automatic int model_perr(input logic [7:0] d,
                                    input logic pb);
    return (($countones(d) + int'(pb)) % 2 != 0) ? 1 : 0;
  endfunction

  task automatic send(input int d, input logic [15:0] f,
                      input int n, input int rst_bit,
                      input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      set_rx(d, f[i]);
      if (i == rst_bit) begin
        tick(20);
        rst_c = 1'b1;
        tick(3);
        rst_c = 1'b0;
        tick(1);
        chk("rst_mid/m_valid", 32'(mv_c), 32'd0);
        tick(BIT - 24);
      end else if (i == glitch_bit) begin
        tick(BIT / 2 - 2);
        set_rx(d, ~f[i]);
        tick(4);
        set_rx(d, f[i]);
        tick(BIT / 2 - 2);
      end else begin
        tick(BIT);
      end
    end
    set_rx(d, 1'b1);
  endtask

  task automatic idle(input int nbits);
    tick(nbits * BIT);
  endtask

  initial begin
    logic [15:0] f;
    logic [7:0] rb[6];
    logic pbs[6];
    int exp_pe;
    int n;

    tick(5);
    chk("rst/a_valid", 32'(mv_a), 32'd0);
    chk("rst/a_data", 32'(md_a), 32'd0);
    chk("rst/a_perr", 32'(pe_a), 32'd0);
    chk("rst/a_ferr", 32'(fe_a), 32'd0);
    chk("rst/a_brk", 32'(bk_a), 32'd0);
    chk("rst/a_ovr", 32'(ov_a), 32'd0);
    chk("rst/b_valid", 32'(mv_b), 32'd0);
    chk("rst/b_data", 32'(md_b), 32'd0);
    chk("rst/c_valid", 32'(mv_c), 32'd0);
    chk("rst/c_data", 32'(md_c), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    idle(2);

    snap(0);
    send(0, mk(9'h0A5, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1);
    idle(2);
    deltas("a5", 0, 1, 0, 0, 0, 0);
    chk("a5/data", 32'(gat(0, bdv[0])), 32'h0A5);
    chk("a5/valid_drop", 32'(mv_a), 32'd0);

    snap(0);
    for (int i = 0; i < 6; i++) begin
      rb[i] = 8'($urandom_range(0, 255));
      send(0, mk(9'(rb[i]), 8, 0, 1'b0, 1, 1'b1), 10, -1, -1);
      idle(1);
    end
    deltas("rnd8n1", 0, 6, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      chk("rnd8n1/data", 32'(gat(0, bdv[0] + i)), 32'(rb[i]));

    snap(1);
    send(1, mk(9'h003, 8, 1, 1'b1, 1, 1'b1), 11, -1, -1);
    idle(2);
    deltas("8e1_bad", 1, 1, model_perr(8'h03, 1'b1), 0, 0, 0);
    chk("8e1_bad/data", 32'(gat(1, bdv[1])), 32'h003);
    snap(1);
    send(1, mk(9'h003, 8, 1, 1'b0, 1, 1'b1), 11, -1, -1);
    idle(2);
    deltas("8e1_ok", 1, 1, model_perr(8'h03, 1'b0), 0, 0, 0);

    snap(1);
    exp_pe = 0;
    for (int i = 0; i < 6; i++) begin
      rb[i] = 8'($urandom_range(0, 255));
      pbs[i] = 1'($urandom_range(0, 1));
      exp_pe += model_perr(rb[i], pbs[i]);
      send(1, mk(9'(rb[i]), 8, 1, pbs[i], 1, 1'b1), 11, -1, -1);
      idle(1);
    end
    deltas("rnd8e1", 1, 6, exp_pe, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      chk("rnd8e1/data", 32'(gat(1, bdv[1] + i)), 32'(rb[i]));

    snap(0);
    rx_a = 1'b0;
    tick(4);
    rx_a = 1'b1;
    idle(2);
    deltas("false_start", 0, 0, 0, 0, 0, 0);

    snap(0);
    send(0, mk(9'h000, 8, 0, 1'b0, 1, 1'b1), 10, -1, 4);
    idle(2);
    deltas("glitch", 0, 1, 0, 0, 0, 0);
    chk("glitch/data", 32'(gat(0, bdv[0])), 32'h000);

    snap(0);
    send(0, mk(9'h055, 8, 0, 1'b0, 1, 1'b0), 10, -1, -1);
    idle(2);
    deltas("bad_stop", 0, 0, 0, 1, 0, 0);
    chk("bad_stop/valid", 32'(mv_a), 32'd0);

    snap(0);
    rx_a = 1'b0;
    idle(12);
    rx_a = 1'b1;
    idle(2);
    deltas("break", 0, 0, 0, 0, 1, 0);

    snap(0);
    send(0, mk(9'h07E, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1);
    idle(2);
    deltas("after_brk", 0, 1, 0, 0, 0, 0);
    chk("after_brk/data", 32'(gat(0, bdv[0])), 32'h07E);

    mr_a = 1'b0;
    snap(0);
    send(0, mk(9'h011, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1);
    idle(2);
    send(0, mk(9'h022, 8, 0, 1'b0, 1, 1'b1), 10, -1, -1);
    idle(2);
    deltas("overrun", 0, 0, 0, 0, 0, 1);
    chk("overrun/data", 32'(md_a), 32'h011);
    chk("overrun/valid", 32'(mv_a), 32'd1);
    mr_a = 1'b1;
    tick(2);
    chk("drain/valid", 32'(mv_a), 32'd0);
    chk("drain/count", 32'(gsize(0) - bdv[0]), 32'd1);
    chk("drain/data", 32'(gat(0, bdv[0])), 32'h011);

    f = mk(9'h1FF, 9, 0, 1'b0, 2, 1'b1);
    n = flen(9, 0, 2);
    snap(2);
    for (int i = 0; i < 3; i++) send(2, f, n, -1, -1);
    idle(2);
    deltas("9n2_b2b", 2, 3, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      chk("9n2_b2b/data", 32'(gat(2, bdv[2] + i)), 32'h1FF);

    snap(2);
    send(2, f, n, -1, -1);
    send(2, f, n, 3, -1);
    send(2, f, n, -1, -1);
    idle(2);
    deltas("9n2_rst", 2, 2, 0, 0, 0, 0);
    chk("9n2_rst/data0", 32'(gat(2, bdv[2])), 32'h1FF);
    chk("9n2_rst/data1", 32'(gat(2, bdv[2] + 1)), 32'h1FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_ex.md
Name: uart_rx_ex

Overview:
- Parametrised next-generation UART receiver: configurable data width, parity, stop-bit count and oversampling ratio.
- 3-sample majority-vote bit detection; per-frame error reporting (parity, framing, break, overrun).
- One-entry valid/ready output buffer, so downstream logic can stall for up to one frame time without losing data.
- Sits between the board RX pin (plus shared baud-tick generator) and command/FIFO logic.

Parameters:
- OS, 16, os_tick pulses per bit; must be even and ≥ 8.
- DATA_W, 8, data bits per frame (5..9), LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits expected (1 or 2).

Ports:
- CLK  in  1  system clock
- rst  in  1  reset: synchronous, active-high (clock CLK)
- os_tick  in  1  single-CLK pulse at OS×baud
- RX  in  1  asynchronous serial input; idle high
- m_data  out  DATA_W  received word, valid while m_valid = 1
- m_valid  out  1  output buffer holds a word
- m_ready  in  1  consumer accepts; transfer happens when m_valid & m_ready
- parity_err  out  1  1-CLK pulse, with the delivered frame
- framing_err  out  1  1-CLK pulse, stop bit sampled 0 (non-break)
- break_det  out  1  1-CLK pulse, break condition detected
- overrun  out  1  1-CLK pulse, frame dropped because buffer full

Behaviour:
- Input path:
  - RX passes through a 2-flop synchroniser (rx_sync); both flops reset to 1.
  - All FSM and sampling logic advances only on cycles with os_tick = 1.
- Bit timing:
  - phase counter runs 0..OS-1 within each bit.
  - rx_sync is sampled at phases OS/2-1, OS/2 and OS/2+1.
  - Bit value = majority of the 3 samples.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on rx_sync = 0, set phase = 1 (the detect tick counts as phase 0) and go to START.
  - START: at phase OS-1, if majority = 1 it is a false start → IDLE with no pulse. Otherwise phase = 0, bit_idx = 0 → DATA.
  - DATA: at phase OS-1, shift the bit in LSB-first. After DATA_W bits go to PARITY if PARITY ≠ 0, else STOP.
  - PARITY: at phase OS-1, capture the parity bit and go to STOP.
  - STOP, with STOP_BITS = 2: the first stop bit runs the full OS ticks.
  - STOP, final stop bit: the frame is evaluated at phase OS/2+1, the tick of the last vote sample, then the FSM returns to IDLE. This gives ½-bit margin for resynchronisation on the next start edge.
  - Any stop bit with majority 0 is a failure, and the frame is evaluated immediately.
  - BREAK: wait until rx_sync = 1 on an os_tick, then go to IDLE; no further pulses.
- Frame evaluation (pulses asserted on the CLK cycle after the evaluating tick):
  - Break: data = 0, parity bit = 0 (if present), and the failing stop bit = 0 → break_det, go to BREAK, no data delivered, no framing_err.
  - Failed stop bit, not a break → framing_err, no data delivered.
  - Otherwise the frame is good → delivered. parity_err pulses with it if the computed parity mismatches; the data is still delivered.
- Delivery into the output buffer:
  - Buffer empty, or m_ready = 1 on the same cycle → m_data loads the new word and m_valid = 1.
  - Buffer full and m_ready = 0 → new word dropped, old word kept, overrun pulses. parity_err for the dropped frame is suppressed.
- Output handshake:
  - m_valid & m_ready with no new word arriving → m_valid = 0 next cycle.
  - m_data holds its value while m_valid = 1 and m_ready = 0.
- Reset values: m_data = 0, m_valid = 0, all error pulses 0, state IDLE, phase 0, shifter 0.
- Reset mid-frame: the frame is abandoned silently, no pulses; the buffered word is discarded.
- os_tick = 0 for any length of time: state is frozen; the output handshake still operates every CLK.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - FSM state encodings;
  - parity helper function (XOR-reduce plus mode).
- One sub-module, uart_rx_sampler:
  - owns the 2-flop synchroniser, the phase counter compare and the 3-sample majority vote;
  - outputs rx_sync, sample_bit and bit_done strobes.
- FSM, shifter, evaluation and output buffer stay in uart_rx_ex.

Test Plan:
1. Defaults (8N1, OS=16), send 0xA5 with m_ready = 1 → m_valid pulses one cycle with m_data = 0xA5; no error pulses.
2. PARITY = 1 (8E1): send 0x03 with parity bit 1 → m_data = 0x03 delivered and parity_err pulses once. Same byte with parity bit 0 → no parity_err.
3. Glitches: a 1-os_tick low glitch on an idle line → no output (false start). A 1-tick inverted glitch at phase OS/2 of data bit 3 of 0x00 → m_data = 0x00 (majority rejects).
4. Bad stop: send 0x55 with the stop bit driven 0 → framing_err pulse, m_valid stays 0. Hold RX low for 12 bit times → break_det pulses once. Release RX, then send 0x7E → delivered normally.
5. Overrun: m_ready = 0, send 0x11 then 0x22 → m_data stays 0x11 and overrun pulses once at the second frame. Raise m_ready → 0x11 transferred and m_valid drops.
6. DATA_W = 9, STOP_BITS = 2: send 0x1FF back-to-back three times → three deliveries of 0x1FF. Assert rst during the second frame's data bits → no pulses, m_valid = 0; the third frame after rst deasserts is received correctly.
